// File: rtl/sync_fifo_buf.sv
// sync_fifo_buf
//   Synchronous first-word-fall-through FIFO buffer with valid/ready
//   handshakes on both sides. The storage array has no reset. Words are
//   discarded by clearing the pointers.
//
// Parameters
//   DATA_WIDTH : payload width in bits
//   DEPTH      : number of entries (a power of two, >= 2)
//
// Ports
//   clk        : clock; all state changes happen on its rising edge
//   rst        : asynchronous, active-high reset
//   in_data    : upstream payload
//   in_valid   : upstream offers in_data
//   in_ready   : registered; the buffer can accept a word this cycle
//   out_data   : word at the read pointer (first-word fall-through)
//   out_valid  : out_data holds a stored word
//   out_ready  : downstream accepts out_data this cycle
//   level      : occupancy 0..DEPTH. This port exists only when the
//                BUF_LEVEL_EN macro is defined.
//
// Optional feature macro: BUF_LEVEL_EN

module sync_fifo_buf #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef BUF_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0]  level
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

    // Each pointer carries one extra MSB that acts as a wrap bit. With it,
    // full and empty can be told apart when the low bits are equal.
    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic                  in_ready_q, in_ready_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  empty;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic [AW:0]           occ_d;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // in_ready_q is zero whenever the buffer is full. A push is therefore
    // never accepted on the same edge as the pop that frees a slot.
    assign push = in_valid && in_ready_q;
    assign pop  = !empty && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        occ_d      = wr_ptr_d - rd_ptr_d;
        in_ready_d = (occ_d != FULL_OCC);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            in_ready_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            in_ready_q <= in_ready_d;
        end
    end

    // The storage array is deliberately left unreset. Clearing the
    // pointers already discards every stored word.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_data;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = !empty;
    assign out_data  = mem_q[rd_ptr_q[AW-1:0]];

`ifdef BUF_LEVEL_EN
    assign level = wr_ptr_q - rd_ptr_q;
`endif

endmodule

// File: tb/tb_sync_fifo_buf.sv
// Testbench for sync_fifo_buf (DEPTH=4, DATA_WIDTH=8).
// The reference is a word queue: the buffer contents are the queue, and
// in_ready is "the queue will not be full after this edge".

module tb_sync_fifo_buf;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          out_ready;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
`ifdef BUF_LEVEL_EN
    logic [2:0]    level;
`endif

    sync_fifo_buf #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef BUF_LEVEL_EN
        ,
        .level     (level)
`endif
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model
    logic [DW-1:0] mq[$];
    bit            m_rdy;
    bit            m_push;
    bit            m_pop;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_rdy = 1'b0;
        end else begin
            m_push = in_valid && m_rdy;
            m_pop  = (mq.size() != 0) && out_ready;
            if (m_pop) void'(mq.pop_front());
            if (m_push) mq.push_back(in_data);
            m_rdy = (mq.size() != DEPTH);
        end
    end

    // Per-cycle compare, away from the active edge
    logic [DW-1:0] prev_data;
    bit            prev_stall = 1'b0;
    bit            sb_en      = 1'b0;
    int            sb_next    = 0;
    int            sb_pop_cnt = 0;

    always @(negedge clk) begin
        check("out_valid", {31'b0, out_valid}, {31'b0, (mq.size() != 0)});
        check("in_ready", {31'b0, in_ready}, {31'b0, m_rdy});
        if (mq.size() != 0) check("out_data", {24'b0, out_data}, {24'b0, mq[0]});
`ifdef BUF_LEVEL_EN
        check("level", {29'b0, level}, mq.size());
`endif
        if (prev_stall && !rst && out_valid)
            check("stall_hold", {24'b0, out_data}, {24'b0, prev_data});
        if (sb_en && out_valid && out_ready) begin
            check("sb_order", {24'b0, out_data}, {24'b0, sb_next[7:0]});
            sb_next++;
            sb_pop_cnt++;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] v;
    int            push_cnt;
    int            cyc;
    bit            acc;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        step();
        step();
        rst = 1'b0;
        step();
        check("release_in_ready", {31'b0, in_ready}, 32'd1);
        check("release_out_valid", {31'b0, out_valid}, 32'd0);

        // fill
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            v        = 8'h11 * (i + 1);
            in_data  = v;
            step();
        end
        check("fill_in_ready", {31'b0, in_ready}, 32'd0);
        check("fill_model_size", mq.size(), 32'd4);
`ifdef BUF_LEVEL_EN
        check("fill_level", {29'b0, level}, 32'd4);
`endif
        in_data = 8'h55;
        step();
        step();
        in_valid = 1'b0;
        check("fill_reject_size", mq.size(), 32'd4);
        check("fill_head", {24'b0, out_data}, 32'h11);

        // drain
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            v = 8'h11 * (i + 1);
            check("drain_data", {24'b0, out_data}, {24'b0, v});
            step();
        end
        check("drain_empty", {31'b0, out_valid}, 32'd0);
        out_ready = 1'b0;

        // concurrency across the pointer wrap
        in_valid = 1'b1;
        in_data  = 8'hA0;
        step();
        in_data  = 8'hA1;
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            v       = 8'hA2 + i[7:0];
            in_data = v;
            v       = 8'hA0 + i[7:0];
            check("conc_data", {24'b0, out_data}, {24'b0, v});
            step();
            check("conc_size", mq.size(), 32'd2);
`ifdef BUF_LEVEL_EN
            check("conc_level", {29'b0, level}, 32'd2);
`endif
        end
        in_valid = 1'b0;
        step();
        step();
        out_ready = 1'b0;
        check("conc_empty", {31'b0, out_valid}, 32'd0);

        // full plus pop
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            v        = 8'h11 * (i + 1);
            in_data  = v;
            step();
        end
        in_data   = 8'h99;
        out_ready = 1'b1;
        check("fp_head", {24'b0, out_data}, 32'h11);
        check("fp_not_ready", {31'b0, in_ready}, 32'd0);
        step();
        out_ready = 1'b0;
        check("fp_in_ready", {31'b0, in_ready}, 32'd1);
        check("fp_next_head", {24'b0, out_data}, 32'h22);
        check("fp_size", mq.size(), 32'd3);
        step();
        in_valid = 1'b0;
        check("fp_refill_size", mq.size(), 32'd4);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        out_ready = 1'b0;

        // async reset mid-stream with two words stored
        in_valid = 1'b1;
        in_data  = 8'h61;
        step();
        in_data  = 8'h62;
        step();
        in_valid = 1'b0;
        check("pre_rst_valid", {31'b0, out_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_out_valid", {31'b0, out_valid}, 32'd0);
        check("async_in_ready", {31'b0, in_ready}, 32'd0);
`ifdef BUF_LEVEL_EN
        check("async_level", {29'b0, level}, 32'd0);
`endif
        step();
        rst = 1'b0;
        step();
        check("rerelease_in_ready", {31'b0, in_ready}, 32'd1);
        check("rerelease_out_valid", {31'b0, out_valid}, 32'd0);

        // random backpressure, 1000 words 0x00..0xFF repeating
        sb_en    = 1'b1;
        push_cnt = 0;
        cyc      = 0;
        while ((push_cnt < 1000 || sb_pop_cnt < 1000) && cyc < 20000) begin
            in_valid  = (push_cnt < 1000) && ($urandom_range(0, 3) != 0);
            in_data   = push_cnt[7:0];
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) push_cnt++;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sb_en     = 1'b0;
        check("sb_pushed", push_cnt, 32'd1000);
        check("sb_popped", sb_pop_cnt, 32'd1000);
        step();
        check("sb_final_empty", {31'b0, out_valid}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sync_fifo_buf.md
SYNC_FIFO_BUF -- requirements
Module: sync_fifo_buf

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 4: entry count; a power of two, >= 2.
REQ-003 SHALL have port clk  input  1: clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-005 SHALL have port in_data  input  DATA_WIDTH: upstream payload.
REQ-006 SHALL have port in_valid  input  1: upstream offers in_data.
REQ-007 SHALL have port in_ready  output  1: buffer can accept a word this cycle.
REQ-008 SHALL have port out_data  output  DATA_WIDTH: payload to downstream data_sink.
REQ-009 SHALL have port out_valid  output  1: out_data holds a stored word.
REQ-010 SHALL have port out_ready  input  1: downstream accepts out_data this cycle.
REQ-011 SHALL have port level  output  log2(DEPTH)+1: current occupancy; present only under BUF_LEVEL_EN.

Function
REQ-012 SHALL perform a push on a rising edge when in_valid && in_ready.
REQ-013 SHALL perform a pop on a rising edge when out_valid && out_ready.
REQ-014 SHALL store words in DEPTH-entry storage; write and read pointers are log2(DEPTH)+1 bits, the MSB being the wrap bit.
REQ-015 SHALL declare empty when the pointers are equal.
REQ-016 SHALL declare full when the low bits are equal and the wrap bits differ.
REQ-017 SHALL drive out_valid = !empty, combinationally from registered state.
REQ-018 SHALL drive out_data = storage[read pointer low bits] (first-word fall-through).
REQ-019 SHALL drive out_data with the stored word at the read pointer when empty; out_data is don't-care then.
REQ-020 SHALL make in_ready a register updated each edge to !full_next (full_next = occupancy after this edge's push/pop).
REQ-021 SHALL present a word pushed at edge N with out_valid=1 after edge N (one-cycle latency, no bypass).
REQ-022 SHALL, on a simultaneous push and pop with 0 < occupancy < DEPTH, leave occupancy unchanged and advance both pointers.
REQ-023 SHALL, when full, hold in_ready=0, ignore in_valid, and leave storage unmodified.
REQ-024 SHALL, when full and a pop occurs, raise in_ready after that edge; a push is accepted the cycle after, never on the same edge.
REQ-025 SHALL, when empty, not decrement any state even if out_ready=1.
REQ-026 SHALL wrap pointers modulo 2*DEPTH with no lost or duplicated words; delivery order is strictly FIFO.
REQ-027 SHALL hold out_data stable while out_valid=1 and out_ready=0.

Reset
REQ-028 SHALL, while rst=1, force: both pointers 0, out_valid=0, in_ready=0, level=0.
REQ-029 SHALL not reset storage contents.
REQ-030 SHALL set in_ready to 1 at the first rising clk edge after rst deasserts.
REQ-031 SHALL, if rst asserts mid-operation, discard all stored words immediately; out_valid falls without waiting for a clock.

Configuration
REQ-032 SHALL, with BUF_LEVEL_EN defined, add port level = write pointer - read pointer (modulo 2*DEPTH), registered with the pointers, range 0..DEPTH.
REQ-033 SHALL, without BUF_LEVEL_EN, omit port level and its logic entirely; all other behaviour is identical.

Verification (DEPTH=4, DATA_WIDTH=8)
REQ-034 SHALL verify reset: rst pulse mid-stream with 2 words stored -> out_valid=0 and in_ready=0 asynchronously; in_ready=1 one edge after release; level=0.
REQ-035 SHALL verify fill: push 0x11, 0x22, 0x33, 0x44 with out_ready=0 -> in_ready=0 after 4th edge; level=4; 0x55 offered is not stored.
REQ-036 SHALL verify drain: from full, out_ready=1 -> out_data sequence 0x11, 0x22, 0x33, 0x44 on four consecutive edges; then out_valid=0.
REQ-037 SHALL verify concurrency: occupancy 2, push and pop every cycle for 10 cycles -> level stays 2; output order matches input order across pointer wrap.
REQ-038 SHALL verify full plus pop: full, in_valid=1, out_ready=1 for one cycle -> 0x11 popped, nothing pushed that edge, in_ready=1 next cycle.
REQ-039 SHALL verify backpressure: random in_valid/out_ready, 1000 words 0x00..0xFF repeating -> scoreboard shows no loss, no duplication, out_data stable while stalled.
